// File: rtl/timer_arbiter_pkg.sv
// rtl/timer_arbiter_pkg.sv - shared types and sizing helpers for the timer arbiter
package timer_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_REQ_DEFAULT = 4;

  // rr_ptr / owner index width for a given requester count (never below 1 bit)
  function automatic int rr_ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int RR_W_DEFAULT = rr_ptr_w(N_REQ_DEFAULT);

endpackage

// File: rtl/timer_rr_pick.sv
// rtl/timer_rr_pick.sv - combinational round-robin selector starting at rr_ptr
module timer_rr_pick
  import timer_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int PW    = RR_W_DEFAULT
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic             valid,
  output logic [PW-1:0]    winner
);

  // scan from the farthest slot back to rr_ptr so the nearest set bit wins
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % N_REQ]) begin
        valid  = 1'b1;
        winner = PW'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - one shared up-counter granted round-robin to N_REQ requesters
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] len,
  output logic [N_REQ-1:0]    grant,
  output logic                busy,
  output logic [N_REQ-1:0]    done,
  output logic [CW-1:0]       count
);

  localparam int PW = rr_ptr_w(N_REQ);

  state_t           state_q, state_d;
  logic [PW-1:0]    g_q, g_d;
  logic [PW-1:0]    rr_ptr, rr_d;
  logic [CW-1:0]    len_q, len_d;
  logic [N_REQ-1:0] grant_d, done_d;
  logic [CW-1:0]    count_d;
  logic             busy_d;
  logic             pick_valid;
  logic [PW-1:0]    pick_win;
  logic [PW-1:0]    ptr_after_owner;

  timer_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_win)
  );

  assign ptr_after_owner = (int'(g_q) == N_REQ - 1) ? '0 : g_q + 1'b1;

  // state and registered outputs; reset clears everything, interrupted transactions get no done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_ptr  <= '0;
      len_q   <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_ptr  <= rr_d;
      len_q   <= len_d;
      grant   <= grant_d;
      done    <= done_d;
      busy    <= busy_d;
      count   <= count_d;
    end
  end

  // next-state: grant on any request, abort on owner drop, finish at terminal count
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = RUN;
      RUN: begin
        if (!req[g_q])          state_d = IDLE;
        else if (count == len_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs, owner latch and rotation pointer
  always_comb begin
    grant_d = grant;
    done_d  = '0;
    busy_d  = busy;
    count_d = count;
    g_d     = g_q;
    len_d   = len_q;
    rr_d    = rr_ptr;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        if (pick_valid) begin
          grant_d = N_REQ'(1) << pick_win;
          busy_d  = 1'b1;
          g_d     = pick_win;
          len_d   = len[int'(pick_win)*CW +: CW];
        end
      end
      RUN: begin
        if (!req[g_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
          rr_d    = ptr_after_owner;
        end else if (count == len_q) begin
          done_d = grant;
        end else begin
          count_d = count + 1'b1;
        end
      end
      DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        rr_d    = ptr_after_owner;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - directed scoreboard bench for timer_arbiter
module tb_timer_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*CW-1:0] len;
  logic [N-1:0]    grant;
  logic            busy;
  logic [N-1:0]    done;
  logic [CW-1:0]   count;

  int checks;
  int errors;
  int exp_q[$];
  logic prev_done;

  timer_arbiter #(.N_REQ(N), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .grant (grant),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int idx, input int val);
    len[idx*CW +: CW] = CW'(val);
  endtask

  // waits for the grant, checks owner and latency to done, releases req, returns to IDLE
  task automatic serve(input int idx, input int l);
    int k;
    k = 0;
    while (grant == '0 && k < 40) begin
      step();
      k++;
    end
    chk("serve_grant", 32'(grant), 32'(1 << idx));
    k = 0;
    while (done == '0 && k < 300) begin
      step();
      k++;
    end
    chk("serve_latency", 32'(k), 32'(l + 1));
    req[idx] = 1'b0;
    step();
  endtask

  // scoreboard: every done pulse must match the next expected owner; plus invariants
  always @(negedge clk) begin
    if (rst) begin
      if (done != '0) begin
        if (exp_q.size() == 0) chk("done_unexpected", 32'(done), 32'(0));
        else chk("done_owner", 32'(done), 32'(1 << exp_q.pop_front()));
        chk("done_in_grant", 32'(done & ~grant), 32'(0));
        chk("done_not_back_to_back", 32'(prev_done), 32'(0));
      end
      chk("grant_onehot0", 32'($onehot0(grant)), 32'(1));
      prev_done <= (done != '0);
    end else begin
      prev_done <= 1'b0;
    end
  end

  initial begin
    int k;
    int last_cnt;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    req = '0;
    len = '0;
    repeat (3) step();
    chk("reset_grant", 32'(grant), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_count", 32'(count), 32'(0));
    rst = 1'b1;
    step();

    // single requester, len 3
    set_len(1, 3);
    req = 4'b0010;
    exp_q.push_back(1);
    step();
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("t1_count", 32'(count), 32'(c));
      chk("t1_nodone", 32'(done), 32'd0);
    end
    step();
    chk("t1_done", 32'(done), 32'h2);
    req = '0;
    step();
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_idle_count", 32'(count), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // zero length
    set_len(0, 0);
    req = 4'b0001;
    exp_q.push_back(0);
    step();
    chk("t2_grant", 32'(grant), 32'h1);
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_busy1", 32'(busy), 32'd1);
    step();
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_busy2", 32'(busy), 32'd1);
    req = '0;
    step();
    chk("t2_busy_end", 32'(busy), 32'd0);

    // round-robin fairness from a fresh pointer
    rst = 1'b0;
    step();
    rst = 1'b1;
    set_len(0, 1);
    set_len(1, 2);
    set_len(2, 0);
    set_len(3, 3);
    for (int pass = 0; pass < 2; pass++) begin
      req = 4'b1111;
      for (int i = 0; i < N; i++) exp_q.push_back(i);
      serve(0, 1);
      serve(1, 2);
      serve(2, 0);
      serve(3, 3);
    end

    // abort at count 4, next search starts at 3
    set_len(2, 10);
    req = 4'b0100;
    step();
    chk("t4_grant", 32'(grant), 32'h4);
    k = 0;
    while (count != 4'd4 && k < 20) begin
      step();
      k++;
    end
    chk("t4_count4", 32'(count), 32'd4);
    req = '0;
    step();
    chk("t4_abort_grant", 32'(grant), 32'd0);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_count", 32'(count), 32'd0);
    set_len(0, 0);
    set_len(3, 1);
    req = 4'b1001;
    exp_q.push_back(3);
    exp_q.push_back(0);
    serve(3, 1);
    serve(0, 0);

    // max length with len change after grant
    set_len(3, 15);
    req = 4'b1000;
    exp_q.push_back(3);
    step();
    chk("t5_grant", 32'(grant), 32'h8);
    k = 0;
    last_cnt = 0;
    while (done == '0 && k < 40) begin
      last_cnt = int'(count);
      step();
      k++;
      if (k == 2) set_len(3, 2);
    end
    chk("t5_latency", 32'(k), 32'd16);
    chk("t5_last_count", 32'(last_cnt), 32'd15);
    req = '0;
    step();
    chk("t5_idle_count", 32'(count), 32'd0);

    // async reset mid-RUN at count 7
    set_len(2, 10);
    req = 4'b0100;
    step();
    k = 0;
    while (count != 4'd7 && k < 20) begin
      step();
      k++;
    end
    chk("t6_count7", 32'(count), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    step();
    step();
    rst = 1'b1;
    set_len(2, 1);
    exp_q.push_back(2);
    serve(2, 1);

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
